// File: rtl/transpose_tile_writer.sv
// Drains transposed 512-bit lines from the upstream FIFO and writes them to mirrored tile addresses.
// Latency: fifo_re at cycle t gives wr_valid no earlier than cycle t+2; one write per cycle sustained.
// Backpressure: wr_ready low holds wr_addr/wr_data; fetching stops once buffer occupancy plus in-flight reads fill BUF_DEPTH.
module transpose_tile_writer #(
  parameter int LINE_WIDTH = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int DIM_WIDTH  = 8,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [DIM_WIDTH-1:0]  cfg_tiles_per_row,
  input  logic [DIM_WIDTH-1:0]  cfg_tiles_per_col,
  output logic                  busy,
  output logic                  done,
  input  logic [LINE_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_re,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [LINE_WIDTH-1:0] wr_data
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int FW = 2 * DIM_WIDTH + 5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_nxt;
  logic [DIM_WIDTH-1:0]  tpr_q, tpc_q;
  logic [FW-1:0]         fetched_q, total_q;
  logic                  inflight_q;
  logic [LINE_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [4:0]            line_q;
  logic [DIM_WIDTH-1:0]  tc_q;
  // row_addr_q is cfg_base + tr, so the tile-row counter lives inside it
  logic [ADDR_WIDTH-1:0] addr_q, row_addr_q;

  logic start_ok, dim_zero, push, pop;
  logic [FW-1:0] total_nxt;
  logic [ADDR_WIDTH-1:0] tpc_ext;

  assign start_ok  = (state_q == S_IDLE) && start;
  assign dim_zero  = (cfg_tiles_per_row == '0) || (cfg_tiles_per_col == '0);
  assign total_nxt = (FW'(cfg_tiles_per_row) * FW'(cfg_tiles_per_col)) << 5;
  assign tpc_ext   = ADDR_WIDTH'(tpc_q);
  assign push      = inflight_q;
  assign pop       = wr_valid && wr_ready;

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign wr_valid = (count_q != '0);
  assign wr_addr  = addr_q;
  assign wr_data  = wr_valid ? buf_mem[rd_ptr_q] : '0;

  // Next state and fetch request; reads only when the buffer can absorb every outstanding line
  always_comb begin
    state_nxt = state_q;
    fifo_re   = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_nxt = dim_zero ? S_DONE : S_RUN;
      S_RUN: begin
        fifo_re = !fifo_empty && (fetched_q < total_q) &&
                  ((CW + 1)'(count_q) + (CW + 1)'(inflight_q) < (CW + 1)'(BUF_DEPTH));
        if (fetched_q == total_q) state_nxt = S_DRAIN;
      end
      S_DRAIN: if ((count_q == '0) && !inflight_q) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, job config and fetch accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tpr_q      <= '0;
      tpc_q      <= '0;
      total_q    <= '0;
      fetched_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      inflight_q <= fifo_re;
      if (start_ok) begin
        tpr_q     <= cfg_tiles_per_row;
        tpc_q     <= cfg_tiles_per_col;
        total_q   <= total_nxt;
        fetched_q <= '0;
      end else if (fifo_re) begin
        fetched_q <= fetched_q + FW'(1);
      end
    end
  end

  // Holding buffer storage; the line arrives the cycle after its read
  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr_q] <= fifo_dout;
  end

  // Holding buffer pointers and occupancy; push and pop together leave occupancy unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Destination address walk: the linear index tc*32+l steps by one per write, i.e. +TPC,
  // and a tile-row wrap restarts at base + tr + 1
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      row_addr_q <= '0;
      line_q     <= '0;
      tc_q       <= '0;
    end else if (start_ok) begin
      addr_q     <= cfg_base;
      row_addr_q <= cfg_base;
      line_q     <= '0;
      tc_q       <= '0;
    end else if (pop) begin
      line_q <= line_q + 5'd1;
      if ((line_q == 5'd31) && (tc_q == tpr_q - DIM_WIDTH'(1))) begin
        tc_q       <= '0;
        row_addr_q <= row_addr_q + ADDR_WIDTH'(1);
        addr_q     <= row_addr_q + ADDR_WIDTH'(1);
      end else begin
        if (line_q == 5'd31) tc_q <= tc_q + DIM_WIDTH'(1);
        addr_q <= addr_q + tpc_ext;
      end
    end
  end

endmodule

// File: tb/tb_transpose_tile_writer.sv
// Scoreboard bench for transpose_tile_writer: upstream FIFO model, random ready/gap stress.
// Latency: expectations queued at load time, compared whenever a write handshake is seen.
// Backpressure: wr_ready and fifo_empty are driven per cycle, optionally randomised.
module tb_transpose_tile_writer;
  localparam int LW = 512;
  localparam int AW = 32;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] cfg_base;
  logic [DW-1:0] cfg_tiles_per_row, cfg_tiles_per_col;
  logic          busy, done;
  logic [LW-1:0] fifo_dout;
  logic          fifo_empty, fifo_re;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [LW-1:0] wr_data;

  transpose_tile_writer dut (
    .clk(clk), .reset(reset), .start(start), .cfg_base(cfg_base),
    .cfg_tiles_per_row(cfg_tiles_per_row), .cfg_tiles_per_col(cfg_tiles_per_col),
    .busy(busy), .done(done), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_re(fifo_re), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  logic [LW-1:0] src_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [LW-1:0] exp_data_q[$];
  int n_chk = 0, n_pass = 0;
  int done_cnt = 0, wr_cnt = 0, re_cnt = 0;
  bit rdy_rand = 0, gaps = 0;
  logic re_q = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_line(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [LW-1:0] mk_line(input int tag, input int idx);
    logic [LW-1:0] ln;
    for (int i = 0; i < LW / 32; i++) ln[i*32 +: 32] = {16'(tag), 16'(idx)};
    return ln;
  endfunction

  // upstream FIFO sees the same read strobe the DUT registered
  always @(posedge clk) re_q <= fifo_re;

  // Upstream FIFO model and write-ready driver, all changes at the falling edge
  initial begin
    fifo_dout = '0; fifo_empty = 1'b1; wr_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (re_q && src_q.size() > 0) fifo_dout = src_q.pop_front();
      fifo_empty = (src_q.size() == 0) || (gaps && $urandom_range(0, 99) < 25);
      wr_ready = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Monitor: scoreboard pop on handshake, stall stability, read-while-empty, done counting
  initial begin
    logic          prev_stall;
    logic [AW-1:0] prev_addr;
    logic [LW-1:0] prev_data;
    prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
    forever begin
      @(negedge clk); #3;
      if (reset) begin prev_stall = 1'b0; continue; end
      if (fifo_re) begin
        re_cnt++;
        chk("re_while_empty", longint'(fifo_empty), 0);
      end
      if (prev_stall) begin
        chk("stall_valid", longint'(wr_valid), 1);
        chk("stall_addr", longint'(wr_addr), longint'(prev_addr));
        chk_line("stall_data", wr_data, prev_data);
      end
      if (wr_valid && wr_ready) begin
        wr_cnt++;
        if (exp_addr_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: got addr %0h expected no write", wr_addr);
        end else begin
          chk("wr_addr", longint'(wr_addr), longint'(exp_addr_q.pop_front()));
          chk_line("wr_data", wr_data, exp_data_q.pop_front());
        end
      end
      prev_stall = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
      if (done) begin
        done_cnt++;
        chk("done_after_last_write", exp_addr_q.size(), 0);
      end
    end
  end

  // Queue source lines in row-major tile order and their mirrored destination addresses
  task automatic load(input logic [AW-1:0] base, input int tpr, input int tpc, input int tag);
    int k = 0;
    for (int tr = 0; tr < tpc; tr++)
      for (int tc = 0; tc < tpr; tc++)
        for (int l = 0; l < 32; l++) begin
          src_q.push_back(mk_line(tag, k));
          exp_data_q.push_back(mk_line(tag, k));
          exp_addr_q.push_back(base + AW'((tc * 32 + l) * tpc + tr));
          k++;
        end
  endtask

  task automatic pulse_start(input logic [AW-1:0] base, input int tpr, input int tpc);
    @(negedge clk);
    cfg_base = base; cfg_tiles_per_row = DW'(tpr); cfg_tiles_per_col = DW'(tpc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_job(input logic [AW-1:0] base, input int tpr, input int tpc,
                         input int tag, input bit chk_re, input bit poke);
    int d0, r0, w0;
    d0 = done_cnt; r0 = re_cnt; w0 = wr_cnt;
    load(base, tpr, tpc, tag);
    pulse_start(base, tpr, tpc);
    if (poke) begin
      repeat (5) @(negedge clk);
      pulse_start(32'h9999, 5, 5);
      cfg_base = base; cfg_tiles_per_row = DW'(tpr); cfg_tiles_per_col = DW'(tpc);
    end
    for (int c = 0; c < 20000; c++) begin
      if (done_cnt != d0) break;
      @(negedge clk); #4;
    end
    repeat (4) @(negedge clk);
    #4;
    chk("done_count", done_cnt - d0, 1);
    chk("write_count", wr_cnt - w0, tpr * tpc * 32);
    chk("lines_left", exp_addr_q.size(), 0);
    chk("idle_busy", longint'(busy), 0);
    chk("idle_valid", longint'(wr_valid), 0);
    if (chk_re) chk("re_cycles", re_cnt - r0, 32);
  endtask

  initial begin
    int d0, r0, w0;
    reset = 1'b1; start = 1'b0; cfg_base = '0; cfg_tiles_per_row = '0; cfg_tiles_per_col = '0;
    repeat (3) @(negedge clk);
    #4;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_fifo_re", longint'(fifo_re), 0);
    chk("rst_wr_valid", longint'(wr_valid), 0);
    chk("rst_wr_addr", longint'(wr_addr), 0);
    chk_line("rst_wr_data", wr_data, '0);
    @(negedge clk);
    reset = 1'b0;

    // single tile, full-rate ready
    run_job(32'h1000, 1, 1, 1, 1, 0);
    // 3x2 tiles: mirrored stride-2 addresses
    run_job(32'h0, 3, 2, 2, 0, 0);

    // zero dimensions: immediate done, no traffic
    for (int z = 0; z < 2; z++) begin
      d0 = done_cnt; r0 = re_cnt; w0 = wr_cnt;
      pulse_start(32'h50, (z == 0) ? 0 : 2, (z == 0) ? 4 : 0);
      #4;
      chk("zero_done_next_cycle", longint'(done), 1);
      repeat (4) @(negedge clk);
      #4;
      chk("zero_done_count", done_cnt - d0, 1);
      chk("zero_reads", re_cnt - r0, 0);
      chk("zero_writes", wr_cnt - w0, 0);
    end

    // random ready and upstream gaps
    rdy_rand = 1; gaps = 1;
    run_job(32'h4000, 1, 1, 4, 0, 0);
    rdy_rand = 0; gaps = 0;

    // reset in the middle of a job, then a clean rerun
    d0 = done_cnt; w0 = wr_cnt;
    load(32'h1000, 1, 1, 5);
    pulse_start(32'h1000, 1, 1);
    for (int c = 0; c < 2000; c++) begin
      if (wr_cnt - w0 >= 10) break;
      @(negedge clk); #4;
    end
    chk("writes_before_reset", (wr_cnt - w0 >= 10) ? 1 : 0, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #4;
    chk("abort_valid", longint'(wr_valid), 0);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_fifo_re", longint'(fifo_re), 0);
    @(negedge clk);
    src_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    chk("abort_no_done", done_cnt - d0, 0);
    run_job(32'h1000, 1, 1, 6, 1, 0);

    // start while busy is ignored
    run_job(32'h200, 2, 1, 7, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
